// File: rtl/multi_bank_spram_param_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : mbank_pkg                                                      |
// | Shared types and geometry helpers for the multi-bank single-port RAM.    |
// | Rev 1.0 : initial parametrised release                                   |
// +--------------------------------------------------------------------------+
package mbank_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } mbank_state_e;

  // Number of address bits used as the bank index (0 for a single bank).
  function automatic int calc_bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 0;
  endfunction

  // Rows held by each bank.
  function automatic int calc_rows(input int depth, input int num_banks);
    return depth / num_banks;
  endfunction

  // Width of an index into n entries, never narrower than one bit.
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_bank_spram_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : multi_bank_spram_param_if                                    |
// | Access bus of the multi-bank RAM: request side from the master, read     |
// | data / strobe / clear-busy back from the RAM.                            |
// | Rev 1.0 : initial parametrised release                                   |
// +--------------------------------------------------------------------------+
interface multi_bank_spram_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic                  en;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     din;
  logic [DATA_W-1:0]     dout;
  logic                  rd_valid;
  logic                  init_busy;

  modport master (
    output en, we, be, addr, din,
    input  dout, rd_valid, init_busy
  );

  modport slave (
    input  en, we, be, addr, din,
    output dout, rd_valid, init_busy
  );
endinterface
`default_nettype wire

// File: rtl/multi_bank_spram_param_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : spram_bank                                                      |
// | One storage bank: single port, per-byte write, registered read.          |
// | Contents are not reset; the top-level clear sequencer zeroes them.       |
// | Rev 1.0 : initial parametrised release                                   |
// +--------------------------------------------------------------------------+
module spram_bank
  import mbank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ROWS   = 8
) (
  input  wire logic                         clk,
  input  wire logic                         en,
  input  wire logic                         we,
  input  wire logic [DATA_W/8-1:0]          be,
  input  wire logic [calc_idx_w(ROWS)-1:0]  row,
  input  wire logic [DATA_W-1:0]            din,
  output logic      [DATA_W-1:0]            dout
);
  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [ROWS];
  logic [DATA_W-1:0] dout_q;

  // Byte-masked write, or registered read of the addressed row.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (be[i]) begin
            mem_q[row][8*i +: 8] <= din[8*i +: 8];
          end
        end
      end else begin
        dout_q <= mem_q[row];
      end
    end
  end

  assign dout = dout_q;
endmodule
`default_nettype wire

// File: rtl/multi_bank_spram_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : multi_bank_spram_param                                          |
// | Low-order interleaved multi-bank single-port RAM with per-byte writes,   |
// | registered read + rd_valid strobe and a post-reset clear sequencer.      |
// | Build option MBANK_OUT_REG_EN: extra output register (read latency 2).   |
// | Rev 1.0 : initial parametrised release                                   |
// +--------------------------------------------------------------------------+
module multi_bank_spram_param
  import mbank_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 32,
  parameter int NUM_BANKS = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  multi_bank_spram_param_if.slave   bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BANK_W = calc_bank_w(NUM_BANKS);
  localparam int ROWS   = calc_rows(DEPTH, NUM_BANKS);
  localparam int ROW_W  = calc_idx_w(ROWS);
  localparam int BSEL_W = calc_idx_w(NUM_BANKS);
  localparam int NBYTES = DATA_W / 8;

  mbank_state_e           state_q, state_d;
  logic [ROW_W-1:0]       cnt_q, cnt_d;
  logic                   w_init;
  logic [BSEL_W-1:0]      w_bank;
  logic [ROW_W-1:0]       w_row;
  logic                   w_access;
  logic                   w_rd_issue;
  logic [NUM_BANKS-1:0]   bank_en;
  logic                   bank_we;
  logic [NBYTES-1:0]      bank_be;
  logic [ROW_W-1:0]       bank_row;
  logic [DATA_W-1:0]      bank_din;
  logic [DATA_W-1:0]      bank_dout [NUM_BANKS];
  logic [BSEL_W-1:0]      sel_q;
  logic                   rdv_q;
  logic                   have_q;
  logic [DATA_W-1:0]      w_mux;
  logic [DATA_W-1:0]      w_stage1;

  // Address split: low bits pick the bank, the rest pick the row.
  generate
    if (NUM_BANKS > 1) begin : g_bank_dec
      assign w_bank = bus.addr[BANK_W-1:0];
    end else begin : g_bank_one
      assign w_bank = '0;
    end
    if (ROWS > 1) begin : g_row_dec
      assign w_row = bus.addr[ADDR_W-1:BANK_W];
    end else begin : g_row_one
      assign w_row = '0;
    end
  endgenerate

  // State and clear-row counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear sequencer: one row of every bank per cycle, then READY until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_init  = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        w_init = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ROW_W'(ROWS - 1)) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
    endcase
  end

  // Requests are honoured only in READY; reset in the same cycle cancels them.
  assign w_access   = (state_q == ST_READY) && bus.en && !rst;
  assign w_rd_issue = w_access && !bus.we;

  // Bank controls: all banks written with zeros while clearing, else only the addressed one.
  always_comb begin
    bank_en  = '0;
    bank_we  = w_init | bus.we;
    bank_be  = w_init ? {NBYTES{1'b1}} : bus.be;
    bank_row = w_init ? cnt_q : w_row;
    bank_din = w_init ? '0 : bus.din;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_en[b] = w_init | (w_access && (w_bank == BSEL_W'(b)));
    end
  end

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      spram_bank #(
        .DATA_W (DATA_W),
        .ROWS   (ROWS)
      ) u_bank (
        .clk  (clk),
        .en   (bank_en[b]),
        .we   (bank_we),
        .be   (bank_be),
        .row  (bank_row),
        .din  (bank_din),
        .dout (bank_dout[b])
      );
    end
  endgenerate

  // Remember which bank the last read went to, and flag the valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdv_q  <= 1'b0;
      have_q <= 1'b0;
      sel_q  <= '0;
    end else begin
      rdv_q <= w_rd_issue;
      if (w_rd_issue) begin
        have_q <= 1'b1;
        sel_q  <= w_bank;
      end
    end
  end

  // Output mux; forced to zero until the first read after reset.
  always_comb begin
    w_mux = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (sel_q == BSEL_W'(b)) begin
        w_mux = bank_dout[b];
      end
    end
    w_stage1 = have_q ? w_mux : '0;
  end

`ifdef MBANK_OUT_REG_EN
  logic [DATA_W-1:0] dout2_q;
  logic              rdv2_q;

  // Second pipeline stage: captures only on a valid read so dout holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout2_q <= '0;
      rdv2_q  <= 1'b0;
    end else begin
      rdv2_q <= rdv_q;
      if (rdv_q) begin
        dout2_q <= w_stage1;
      end
    end
  end

  assign bus.dout     = dout2_q;
  assign bus.rd_valid = rdv2_q;
`else
  assign bus.dout     = w_stage1;
  assign bus.rd_valid = rdv_q;
`endif

  assign bus.init_busy = w_init;
endmodule
`default_nettype wire

// File: tb/tb_multi_bank_spram_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_multi_bank_spram_param                                       |
// | Self-checking bench for multi_bank_spram_param (8/32/4 and 16/32/4).     |
// | Honours MBANK_OUT_REG_EN for the expected read latency.                  |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module tb_multi_bank_spram_param;
  localparam int ROWS = 8;
`ifdef MBANK_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_bank_spram_param_if #(.DATA_W(8),  .ADDR_W(5)) bus8 ();
  multi_bank_spram_param_if #(.DATA_W(16), .ADDR_W(5)) bus16 ();

  multi_bank_spram_param #(.DATA_W(8), .DEPTH(32), .NUM_BANKS(4)) dut (
    .clk (clk), .rst (rst), .bus (bus8)
  );
  multi_bank_spram_param #(.DATA_W(16), .DEPTH(32), .NUM_BANKS(4)) dut16 (
    .clk (clk), .rst (rst), .bus (bus16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain memory array, remaining clear cycles, read-latency queue.
  logic [7:0] ref_mem [32];
  int         init_left = ROWS;
  bit         pq_v [$];
  logic [7:0] pq_d [$];
  bit         exp_v = 1'b0;
  logic [7:0] exp_d = 8'h00;

  task automatic step(input bit r, input bit en, input bit we, input bit be,
                      input logic [4:0] a, input logic [7:0] d);
    bit         ready;
    bit         iss_v;
    logic [7:0] iss_d;
    rst       = r;
    bus8.en   = en;
    bus8.we   = we;
    bus8.be   = be;
    bus8.addr = a;
    bus8.din  = d;
    ready = (init_left == 0) && !r;
    if (r) begin
      foreach (ref_mem[i]) ref_mem[i] = 8'h00;
      init_left = ROWS;
      pq_v.delete();
      pq_d.delete();
      exp_v = 1'b0;
      exp_d = 8'h00;
    end else begin
      iss_v = ready && en && !we;
      iss_d = ref_mem[a];
      if (ready && en && we && be) ref_mem[a] = d;
      if (init_left > 0) init_left--;
      pq_v.push_back(iss_v);
      pq_d.push_back(iss_d);
      exp_v = 1'b0;
      if (pq_v.size() == LAT) begin
        exp_v = pq_v.pop_front();
        iss_d = pq_d.pop_front();
        if (exp_v) exp_d = iss_d;
      end
    end
    @(posedge clk);
    #1;
    check("rd_valid", bus8.rd_valid, exp_v);
    check("dout", bus8.dout, exp_d);
    check("init_busy", bus8.init_busy, init_left > 0);
  endtask

  // Call right after a reset step: counts busy cycles while poking requests.
  task automatic count_init(input string name);
    int busy_cnt = 0;
    int guard    = 0;
    while (bus8.init_busy && guard < 20) begin
      busy_cnt++;
      step(1'b0, 1'b1, guard[0], 1'b1, 5'd2, 8'hEE);
      guard++;
    end
    check(name, busy_cnt, ROWS);
  endtask

  task automatic op16(input bit en, input bit we, input logic [1:0] be,
                      input logic [4:0] a, input logic [15:0] d);
    bus16.en   = en;
    bus16.we   = we;
    bus16.be   = be;
    bus16.addr = a;
    bus16.din  = d;
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  typedef struct {
    bit         we;
    bit         be;
    logic [4:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [14];
  bit   s_v [3];
  logic [7:0] s_d [3];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 5'd5,  8'h5A, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 5'd6,  8'hA6, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 5'd5,  8'h00, 8'h5A};
    tbl[3]  = '{1'b0, 1'b1, 5'd6,  8'h00, 8'hA6};
    tbl[4]  = '{1'b0, 1'b1, 5'd1,  8'h00, 8'h01};
    tbl[5]  = '{1'b1, 1'b0, 5'd9,  8'hFF, 8'h00};
    tbl[6]  = '{1'b0, 1'b1, 5'd9,  8'h00, 8'h09};
    tbl[7]  = '{1'b1, 1'b1, 5'd31, 8'h3C, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 5'd31, 8'h00, 8'h3C};
    tbl[9]  = '{1'b0, 1'b1, 5'd30, 8'h00, 8'h1E};
    tbl[10] = '{1'b1, 1'b1, 5'd5,  8'h77, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 5'd5,  8'h00, 8'h77};
    tbl[12] = '{1'b0, 1'b1, 5'd0,  8'h00, 8'h00};
    tbl[13] = '{1'b0, 1'b1, 5'd17, 8'h00, 8'h11};

    bus16.en = 1'b0; bus16.we = 1'b0; bus16.be = 2'b00; bus16.addr = '0; bus16.din = '0;
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;

    // Reset state, clear length, requests ignored while clearing.
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 8'hEE);
    check("reset_dout", bus8.dout, 8'h00);
    check("reset_busy", bus8.init_busy, 1'b1);
    count_init("init_len_after_reset");

    // All locations read back zero, back-to-back.
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 5'(i), 8'h00);
    for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);

    // Write addr i with i, read back.
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 5'(i), 8'(i));
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 5'(i), 8'h00);
    for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);

    // Table-driven vectors.
    for (int k = 0; k < 14; k++) begin
      if (tbl[k].we) begin
        step(1'b0, 1'b1, 1'b1, tbl[k].be, tbl[k].addr, tbl[k].din);
      end else begin
        step(1'b0, 1'b1, 1'b0, 1'b1, tbl[k].addr, 8'h00);
        for (int j = 1; j < LAT; j++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        check($sformatf("tbl%0d_valid", k), bus8.rd_valid, 1'b1);
        check($sformatf("tbl%0d_dout", k), bus8.dout, tbl[k].exp);
      end
    end

    // Back-to-back reads of addr 3 then 4: valid at +LAT and +LAT+1.
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 8'h00); s_v[0] = bus8.rd_valid; s_d[0] = bus8.dout;
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 8'h00); s_v[1] = bus8.rd_valid; s_d[1] = bus8.dout;
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00); s_v[2] = bus8.rd_valid; s_d[2] = bus8.dout;
    if (LAT == 1) begin
      check("b2b_v1", s_v[0], 1'b1); check("b2b_d1", s_d[0], 8'h03);
      check("b2b_v2", s_v[1], 1'b1); check("b2b_d2", s_d[1], 8'h04);
      check("b2b_v3", s_v[2], 1'b0);
    end else begin
      check("b2b_v1", s_v[0], 1'b0);
      check("b2b_v2", s_v[1], 1'b1); check("b2b_d2", s_d[1], 8'h03);
      check("b2b_v3", s_v[2], 1'b1); check("b2b_d3", s_d[2], 8'h04);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);

    // Fill with FF, reset while a read is issued, then clear again.
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 5'(i), 8'hFF);
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd17, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd17, 8'h00);
    check("rst_abort_valid", bus8.rd_valid, 1'b0);
    count_init("init_len_after_midstream_rst");
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd17, 8'h00);
    for (int j = 1; j < LAT; j++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    check("cleared_addr17", bus8.dout, 8'h00);

    // Reset during INIT restarts the full count.
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    count_init("init_len_after_init_rst");

    // 16-bit instance: byte enables.
    check("w16_busy", bus16.init_busy, 1'b0);
    op16(1'b1, 1'b1, 2'b11, 5'd7, 16'hABCD);
    op16(1'b1, 1'b1, 2'b01, 5'd7, 16'h1234);
    op16(1'b1, 1'b0, 2'b11, 5'd7, 16'h0000);
    for (int j = 1; j < LAT; j++) op16(1'b0, 1'b0, 2'b00, 5'd0, 16'h0000);
    check("w16_valid", bus16.rd_valid, 1'b1);
    check("w16_be01", bus16.dout, 16'hAB34);
    op16(1'b1, 1'b1, 2'b00, 5'd7, 16'hFFFF);
    op16(1'b1, 1'b0, 2'b11, 5'd7, 16'h0000);
    for (int j = 1; j < LAT; j++) op16(1'b0, 1'b0, 2'b00, 5'd0, 16'h0000);
    check("w16_be00", bus16.dout, 16'hAB34);
    op16(1'b0, 1'b0, 2'b00, 5'd0, 16'h0000);

    // Randomised traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 149) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
